// File: rtl/serial_add_seq_if.sv
// rtl/serial_add_seq_if.sv - operand/result handshake and bit-serial adder link for serial_add_seq
//
// Purpose: bundles every non-clock, non-reset signal of serial_add_seq.
//   op_valid/op_ready, a, b     : operand handshake (a, b unsigned, N bits)
//   res_valid/res_ready, res    : result handshake (res is N+1 bits, carry in bit N)
//   busy                        : high whenever the sequencer is not idle
//   add_x/add_y/add_clr/add_sum : link to the external bit-serial adder
// Modports: slave = sequencer side, master = operand source / result sink / adder side.

interface serial_add_seq_if #(
  parameter int N = 8
);
  logic         op_valid;
  logic         op_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         add_x;
  logic         add_y;
  logic         add_clr;
  logic         add_sum;
  logic         res_valid;
  logic         res_ready;
  logic [N:0]   res;
  logic         busy;

  modport slave (
    input  op_valid, a, b, res_ready, add_sum,
    output op_ready, res_valid, res, busy, add_x, add_y, add_clr
  );

  modport master (
    output op_valid, a, b, res_ready, add_sum,
    input  op_ready, res_valid, res, busy, add_x, add_y, add_clr
  );
endinterface

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - sequencer feeding an external bit-serial adder, LSB first
//
// Purpose: accepts two N-bit unsigned operands, clears the external adder,
// streams the operand bits LSB first plus two zero flush steps, and gathers
// the registered sum bits into an N+1 bit result held until taken.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-low reset
//   bus  : serial_add_seq_if.slave (operand/result handshakes, busy, adder link)

module serial_add_seq #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_seq_if.slave  bus
);

  localparam int KW = $clog2(N + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N:0]    res_q;
  logic          bit_a;
  logic          bit_b;
  logic          last_step;

  assign last_step = (k == KW'(N + 1));
  assign bus.res   = res_q;

  // Operand bit for step k; steps N and N+1 fall outside the loop and
  // stay zero, which is what flushes the carry out of the adder.
  always_comb begin
    bit_a = 1'b0;
    bit_b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (k == KW'(i)) begin
        bit_a = a_q[i];
        bit_b = b_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.add_x     = 1'b0;
    bus.add_y     = 1'b0;
    // Holding the adder in clear for the whole reset means an operation
    // aborted mid-stream cannot leave a carry behind.
    bus.add_clr   = !rst;
    case (state)
      IDLE: begin
        bus.op_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.op_valid) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        bus.add_clr = 1'b1;
        state_nxt   = STREAM;
      end
      STREAM: begin
        bus.add_x = bit_a;
        bus.add_y = bit_b;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            a_q <= bus.a;
            b_q <= bus.b;
          end
        end
        CLEAR: begin
          k <= '0;
        end
        STREAM: begin
          if (!last_step) begin
            k <= k + KW'(1);
          end
          // The adder answers one cycle late, so step k returns bit k-1;
          // the final step therefore lands the flushed carry in bit N.
          for (int i = 0; i <= N; i++) begin
            if (k == KW'(i + 1)) begin
              res_q[i] <= bus.add_sum;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
